fifo_rd_ctrl: RTL
=================

Name: fifo_rd_ctrl

Overview:
- Read-side controller for the dual-clock FIFO built around fifomem.
- Runs entirely in the read clock domain and synchronises the Gray-coded write pointer. It generates the memory read address and enable, and the Gray read pointer returned to the write domain.
- Hides fifomem's 1-cycle registered read latency behind a 2-entry valid/ready output buffer, giving downstream logic a stream interface at up to 1 word per clock.

Parameters:
- data_width, 16, word width; must equal the memory's data_width.
- addr_width, 8, memory address bits; FIFO depth = 2**addr_width; pointers are addr_width+1 bits.
- aempty_thresh, 2, rlevel at or below this asserts raempty.

Ports:
- rclk  in  1  read-domain clock, all state on rising edge.
- rrst_n  in  1  asynchronous active-low reset.
- wptr  in  addr_width+1  Gray write pointer from write domain (asynchronous to rclk).
- rdata  in  data_width  memory read data, valid 1 rclk after raddr sampled.
- raddr  out  addr_width  memory read address.
- rclken  out  1  high in a fetch cycle.
- rptr  out  addr_width+1  registered Gray read pointer, to write-domain full logic.
- rempty  out  1  registered; memory holds no unfetched words.
- raempty  out  1  registered; rlevel <= aempty_thresh.
- rlevel  out  addr_width+1  registered count of unfetched words (synced wptr minus read pointer).
- out_data  out  data_width  head word of output buffer.
- out_valid  out  1  out_data holds a word.
- out_ready  in  1  consumer accepts; pop when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release) values:
  - rbin, rptr, raddr, the sync stages, rlevel and out_data are all 0.
  - rempty=1, raempty=1, rclken=0, out_valid=0.
  - Buffer count=0, inflight=0.
- Synchroniser:
  - wptr passes 2 flops (rq1, rq2).
  - rq2 is converted Gray->binary (wbin_s) for level arithmetic only.
- Pointers:
  - rbin is binary, addr_width+1 bits; raddr = rbin[addr_width-1:0].
  - rgraynext = (rbinnext>>1)^rbinnext; rptr registered from rgraynext.
  - Wrap is natural modulo 2**(addr_width+1); the MSB distinguishes laps.
- Empty:
  - rempty <= (rgraynext == rq2), registered every edge.
- Level:
  - rlevel <= wbin_s - rbinnext, modulo addr_width+1 bits.
  - raempty <= (that value <= aempty_thresh).
- Fetch:
  - fetch = !rempty && (count + inflight - pop) < 2, combinational.
  - On fetch: rclken=1 and rbin increments at the edge.
  - The memory samples mem[raddr] at that same edge.
  - inflight is registered as the fetch value.
- Capture:
  - When inflight=1, rdata is written into the buffer at the next edge.
  - Buffer is a 2-entry FIFO; out_data is the oldest entry.
  - Simultaneous capture and pop: count unchanged, order preserved.
  - With out_ready held high, sustained throughput is 1 word/clk.
- Latency (empty FIFO, wptr changes 0->1):
  - rq2 updates at edge 2; rempty falls at edge 3; fetch at edge 4.
  - out_valid rises after edge 5.
- Backpressure:
  - out_ready=0 with count+inflight=2 blocks fetch.
  - rempty stays 0 while words remain in memory.
  - out_data is stable while out_valid && !out_ready.
- Never over-read: fetch is impossible while rempty=1.
- rempty describes memory only. A word may still sit in the buffer with out_valid=1 while rempty=1.
- Reset mid-operation:
  - All state cleared immediately, including inflight; the captured word is discarded.
  - The write side must be reset together with this block.

Decomposition:
- Shared package fifo_pkg:
  - bin2gray and gray2bin functions, parameterised on width.
  - Pointer width rule: addr_width+1.
- Sub-module ptr_sync:
  - 2-flop synchroniser, width parameter, async active-low reset to 0.
  - Also reused by the write-side controller.

Test Plan (data_width=16, addr_width=3, aempty_thresh=2, backed by fifomem plus a behavioural writer):
- Reset, then idle: rempty=1, raempty=1, out_valid=0, rptr=0, rlevel=0, rclken never high.
- Write 0xA5A5 once, out_ready=1: out_valid rises 5 rclk after the wptr change with out_data=0xA5A5, pops next edge; rptr=1, rempty=1.
- Write 8 words 0..7 (full), out_ready=1: outputs 0..7 on consecutive clocks with no bubbles after the first; rlevel steps 8->0; raempty asserts once rlevel<=2.
- Hold out_ready=0 with 8 words stored: exactly 2 fetches occur; out_data=0 held stable; rlevel=6; rempty=0. Release: remaining 7 words arrive in order.
- Wrap: stream 20 words 0x100..0x113 through with randomised out_ready: exact in-order sequence, no duplicates or drops; rptr crosses Gray 0b1000 correctly.
- Assert rrst_n=0 during a fetch cycle (inflight=1): all outputs return to reset values immediately; no stale word appears after release.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: pointer width rule and Gray/binary conversions shared by both FIFO controllers
package fifo_pkg;
  localparam int GW = 32;
  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = g;
    for (int i = 1; i < GW; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/ptr_sync.sv
// ptr_sync: two-flop synchroniser for a Gray pointer entering another clock domain
module ptr_sync #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic [width-1:0] s1_q, s2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  assign q = s2_q;
endmodule

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side FIFO controller with a 2-entry stream buffer hiding the memory read latency
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int data_width    = 16,
  parameter int addr_width    = 8,
  parameter int aempty_thresh = 2
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [addr_width:0]   wptr,
  input  logic [data_width-1:0] rdata,
  output logic [addr_width-1:0] raddr,
  output logic                  rclken,
  output logic [addr_width:0]   rptr,
  output logic                  rempty,
  output logic                  raempty,
  output logic [addr_width:0]   rlevel,
  output logic [data_width-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);
  localparam int pw = ptr_width(addr_width);
  logic [pw-1:0] rq2, wbin_s, rbin_q, rbin_d, rptr_q, rptr_d, rlevel_q, rlevel_d;
  logic rempty_q, rempty_d, raempty_q, raempty_d, inflight_q, fetch, pop, slot;
  logic [1:0] cnt_q, cnt_d, rem;
  logic [data_width-1:0] b0_q, b0_d, b1_q, b1_d;
  ptr_sync #(.width(pw)) u_sync (.clk(rclk), .rst_n(rrst_n), .d(wptr), .q(rq2));
  // words held plus the one in flight may never exceed the two buffer slots
  always_comb begin
    wbin_s    = pw'(gray2bin(GW'(rq2)));
    pop       = (cnt_q != 2'd0) && out_ready;
    fetch     = !rempty_q && ((3'(cnt_q) + 3'(inflight_q) - 3'(pop)) < 3'd2);
    rbin_d    = rbin_q + pw'(fetch);
    rptr_d    = pw'(bin2gray(GW'(rbin_d)));
    rempty_d  = rptr_d == rq2;
    rlevel_d  = wbin_s - rbin_d;
    raempty_d = rlevel_d <= pw'(aempty_thresh);
    cnt_d     = cnt_q + 2'(inflight_q) - 2'(pop);
    rem       = cnt_q - 2'(pop);
    slot      = rem != 2'd0;
    b0_d      = (inflight_q && !slot) ? rdata : pop ? b1_q : b0_q;
    b1_d      = (inflight_q && slot) ? rdata : b1_q;
  end
  always_ff @(posedge rclk or negedge rrst_n)
    if (!rrst_n) begin
      rbin_q     <= '0;
      rptr_q     <= '0;
      rlevel_q   <= '0;
      rempty_q   <= 1'b1;
      raempty_q  <= 1'b1;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
    end else begin
      rbin_q     <= rbin_d;
      rptr_q     <= rptr_d;
      rlevel_q   <= rlevel_d;
      rempty_q   <= rempty_d;
      raempty_q  <= raempty_d;
      inflight_q <= fetch;
      cnt_q      <= cnt_d;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
    end
  assign raddr     = rbin_q[addr_width-1:0];
  assign rclken    = fetch;
  assign rptr      = rptr_q;
  assign rempty    = rempty_q;
  assign raempty   = raempty_q;
  assign rlevel    = rlevel_q;
  assign out_data  = b0_q;
  assign out_valid = cnt_q != 2'd0;
endmodule
